// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering the multicycle CPU's
// mem_read/mem_write handshake with a one-cycle mem_resp pulse after a
// fixed, build-time latency. Malformed requests are completed with mem_err.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               oor_q, oor_d;
  logic               mem_resp_q, mem_resp_d;
  logic               mem_err_q, mem_err_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic               commit_write;

  logic [31:0]        mem_array [DEPTH_WORDS];

  // The low address bits only select a byte within the word, which this
  // word-wide memory never needs.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  assign mem_resp  = mem_resp_q;
  assign mem_err   = mem_err_q;
  assign mem_rdata = mem_rdata_q;

  // Next-state, request capture and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    oor_d        = oor_q;
    mem_resp_d   = 1'b0;
    mem_err_d    = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    commit_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_address[IDX_W+1:2];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          rd_d    = mem_read;
          wr_d    = mem_write;
          oor_d   = |mem_address[31:IDX_W+2];
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        commit_write = !rst && wr_q && !rd_q && !oor_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == RESP) begin
      mem_resp_d = 1'b1;
      mem_err_d  = (rd_d && wr_d) || oor_d;
      if (rd_d && !wr_d) begin
        mem_rdata_d = oor_d ? 32'h0 : mem_array[idx_d];
      end
    end
  end

  // Control state and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      oor_q       <= 1'b0;
      mem_resp_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      oor_q       <= oor_d;
      mem_resp_q  <= mem_resp_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Byte-lane write commit at the end of the response cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_array[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (LATENCY 3 and LATENCY 1) driven with
// directed transactions; expected responses go into per-instance queues and
// a monitor pops and compares them whenever mem_resp is seen.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_rdata, b_rdata;
  logic        a_resp, a_err, b_resp, b_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] last_rd [2];
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (a_rd),
    .mem_write       (a_wr),
    .mem_address     (a_addr),
    .mem_wdata       (a_wdata),
    .mem_byte_enable (a_be),
    .mem_rdata       (a_rdata),
    .mem_resp        (a_resp),
    .mem_err         (a_err)
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (b_rd),
    .mem_write       (b_wr),
    .mem_address     (b_addr),
    .mem_wdata       (b_wdata),
    .mem_byte_enable (b_be),
    .mem_rdata       (b_rdata),
    .mem_resp        (b_resp),
    .mem_err         (b_err)
  );

  // Free-running clock and cycle index used to time-stamp responses.
  always #5 clk = ~clk;

  // Cycle index advances on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Scoreboard monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (a_resp) begin
      checkOutput("A resp not back-to-back", {31'b0, prev_a}, 32'h0);
      if (q_a.size() == 0) begin
        checkOutput("A spurious resp", {31'b0, a_resp}, 32'h0);
      end else begin
        checkOutput("A rdata", a_rdata, q_a[0].rdata);
        checkOutput("A err", {31'b0, a_err}, {31'b0, q_a[0].err});
        checkOutput("A resp cycle", cyc, q_a[0].cyc);
        void'(q_a.pop_front());
      end
    end
    if (b_resp) begin
      checkOutput("B resp not back-to-back", {31'b0, prev_b}, 32'h0);
      if (q_b.size() == 0) begin
        checkOutput("B spurious resp", {31'b0, b_resp}, 32'h0);
      end else begin
        checkOutput("B rdata", b_rdata, q_b[0].rdata);
        checkOutput("B err", {31'b0, b_err}, {31'b0, q_b[0].err});
        checkOutput("B resp cycle", cyc, q_b[0].cyc);
        void'(q_b.pop_front());
      end
    end
    prev_a <= a_resp;
    prev_b <= b_resp;
  end

  // One full handshake: raise the request, hold it until mem_resp, drop it the cycle after.
  task automatic applyStimulus(input bit b, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] rd_exp,
                               input logic err_exp);
    exp_t e;
    bit   seen;
    @(posedge clk);
    #1;
    e.rdata = (rd && !wr) ? rd_exp : last_rd[b];
    e.err   = err_exp;
    e.cyc   = cyc + (b ? 1 : 3);
    last_rd[b] = e.rdata;
    if (b) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata; b_be = be;
      q_b.push_back(e);
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
      q_a.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = b ? b_resp : a_resp;
    end
    if (!seen) begin
      if (b) begin
        checkOutput("B resp timeout", {31'b0, b_resp}, 32'h1);
        void'(q_b.pop_back());
      end else begin
        checkOutput("A resp timeout", {31'b0, a_resp}, 32'h1);
        void'(q_a.pop_back());
      end
    end
    @(posedge clk);
    #1;
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_be = 4'h0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset A resp", {31'b0, a_resp}, 32'h0);
    checkOutput("reset A rdata", a_rdata, 32'h0);
    checkOutput("reset A err", {31'b0, a_err}, 32'h0);
    checkOutput("reset B resp", {31'b0, b_resp}, 32'h0);
    checkOutput("reset B rdata", b_rdata, 32'h0);
    checkOutput("reset B err", {31'b0, b_err}, 32'h0);

    $display("[TB] preload and read latency");
    applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h04, 32'h11223344, 4'hF, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h08, 32'h22222222, 4'hF, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h00, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h0C, 32'h11223344, 4'hF, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);

    $display("[TB] byte-lane writes");
    applyStimulus(0, 0, 1, 32'h04, 32'hAABBCCDD, 4'b0011, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h04, 32'h0, 4'h0, 32'h1122CCDD, 0);
    applyStimulus(0, 0, 1, 32'h0C, 32'hAABBCCDD, 4'b0001, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h0C, 32'h0, 4'h0, 32'h112233DD, 0);
    applyStimulus(0, 0, 1, 32'h10, 32'h00000000, 4'b0000, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);

    $display("[TB] back-to-back fetch and load");
    applyStimulus(0, 1, 0, 32'h00, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    applyStimulus(0, 1, 0, 32'h08, 32'h0, 4'h0, 32'h22222222, 0);

    $display("[TB] abort");
    @(posedge clk);
    #1;
    a_wr = 1'b1; a_addr = 32'h08; a_wdata = 32'hFFFFFFFF; a_be = 4'hF;
    @(posedge clk);
    #1;
    a_wr = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("abort no resp", {31'b0, a_resp}, 32'h0);
    end
    applyStimulus(0, 1, 0, 32'h08, 32'h0, 4'h0, 32'h22222222, 0);

    $display("[TB] reset during write");
    @(posedge clk);
    #1;
    a_wr = 1'b1; a_addr = 32'h00; a_wdata = 32'h0BADBEEF; a_be = 4'hF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_wr = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    checkOutput("rst mid-write resp", {31'b0, a_resp}, 32'h0);
    checkOutput("rst mid-write rdata", a_rdata, 32'h0);
    checkOutput("rst mid-write err", {31'b0, a_err}, 32'h0);
    applyStimulus(0, 1, 0, 32'h00, 32'h0, 4'h0, 32'hCAFEF00D, 0);

    $display("[TB] error cases");
    applyStimulus(0, 1, 1, 32'h00, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    applyStimulus(0, 1, 0, 32'h00, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    applyStimulus(0, 1, 0, 32'h400, 32'h0, 4'h0, 32'h0, 1);
    applyStimulus(0, 0, 1, 32'h404, 32'h0, 4'hF, 32'h0, 1);
    applyStimulus(0, 1, 0, 32'h04, 32'h0, 4'h0, 32'h1122CCDD, 0);

    $display("[TB] LATENCY=1 instance");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 1, i * 4, 32'h5A5A0000 + i * 32'h0101, 4'hF, 32'h0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, i * 4, 32'h0, 4'h0, 32'h5A5A0000 + i * 32'h0101, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("A queue drained", q_a.size(), 32'h0);
    checkOutput("B queue drained", q_b.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable single-port memory that sits on the responder side of the multicycle CPU's memory handshake.
- The CPU control FSM drives mem_read/mem_write plus address, write data and byte enables; this block answers with mem_resp after a programmable latency.
- Used as the instruction/data backing store in sim and FPGA builds, and as the latency-injecting target for control-FSM verification.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
- LATENCY, 3, cycles from request acceptance to mem_resp; range 1..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  read request; initiator holds it high until it sees mem_resp
- mem_write  in  1  write request; same hold rule as mem_read
- mem_address  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_byte_enable  in  4  write lane enables; bit i writes byte lane i, data bits [8i+7:8i]
- mem_rdata  out  32  read data; valid in the mem_resp cycle
- mem_resp  out  1  one-cycle completion pulse
- mem_err  out  1  high with mem_resp when the transaction was rejected

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE; mem_resp=0, mem_rdata=0, mem_err=0; latency counter cleared.
  - Memory array contents are not reset.
  - Reset during BUSY or RESP aborts the transaction; no write commits.
- Word index = mem_address[log2(DEPTH_WORDS)+1:2].
- Out of range: any nonzero bit in mem_address[31:log2(DEPTH_WORDS)+2].
- States:
  - IDLE:
    - (mem_read|mem_write) high -> capture address, wdata, byte_enable and op into holding registers.
    - LATENCY==1 -> go to RESP; otherwise load counter=LATENCY-1 and go to BUSY.
  - BUSY:
    - Decrement counter each cycle; counter reaches 1 -> go to RESP.
    - Request dropping (both low) -> abort to IDLE; no write, no resp.
    - Changes to address, wdata or enables during BUSY are ignored; captured values are used.
  - RESP (registered outputs):
    - mem_resp=1 for exactly this cycle; next state is IDLE.
    - Read: mem_rdata=mem[index] (full word, enables ignored).
    - Write: mem[index] lanes with byte_enable=1 are updated at the end of this cycle; mem_rdata holds its previous value.
- Timing: a request first seen in IDLE in cycle t gives mem_resp high in cycle t+LATENCY.
- Back-to-back: in the cycle after RESP the block is in IDLE. A request high in that cycle is a new transaction. The control FSM guarantees it has already dropped the previous request by then, since its state advanced on mem_resp.
- Error cases (mem_err=1 with mem_resp, same latency):
  - mem_read and mem_write both high at capture: no write; mem_rdata unchanged.
  - Out-of-range address: write discarded; read returns mem_rdata=0.
- Write with byte_enable=4'b0000: legal; resp given, memory unchanged, mem_err=0.
- mem_rdata holds its last value outside RESP cycles.
- mem_resp is never high in two consecutive cycles.
- At most one transaction is outstanding.

Test Plan:
- Read latency: preload mem[4]=32'hDEADBEEF, LATENCY=3; hold mem_read with address 32'h10 from cycle 0 -> mem_resp only in cycle 3, mem_rdata=32'hDEADBEEF, mem_err=0.
- Byte-lane write: mem[1]=32'h11223344; write address 32'h4, wdata 32'hAABBCCDD, enables 4'b0011 -> after resp, reading 32'h4 returns 32'h1122CCDD; enables 4'b0001 on a fresh 32'h11223344 returns 32'h112233DD.
- Back-to-back: fetch-style read at 32'h0, request dropped one cycle after resp, then a load at 32'h8 in the following cycle -> two separate resp pulses, each LATENCY cycles after its own request; no duplicate pulse.
- Abort and reset: mem_write to 32'h8 dropped in cycle 1 -> no resp, mem[2] unchanged. Next, rst pulsed in cycle 2 of a write -> outputs 0, memory unchanged, next request served normally.
- Errors: mem_read and mem_write both high -> resp with mem_err=1, memory unchanged. Read at 32'h0000_0400 with DEPTH_WORDS=256 -> mem_err=1, mem_rdata=0.
- LATENCY=1 build: read request in cycle t -> mem_resp in cycle t+1; ten consecutive reads with one-cycle gaps all return correct data.
